// File: rtl/round_robin_arb_n.sv
// N-channel round-robin FIFO pop arbiter with burst hold, fixed-priority mode
// and downstream stall; select/valid are registered one cycle behind pop.
module round_robin_arb_n #(
  parameter int NUM_CH    = 4,
  parameter int SEL_W     = $clog2(NUM_CH),
  parameter int MAX_BURST = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [NUM_CH-1:0] request,
  input  logic              dest_full,
  input  logic              prio_mode,
  output logic [NUM_CH-1:0] pop,
  output logic [SEL_W-1:0]  port_sel,
  output logic              valid_out
);

  localparam logic [3:0] HOLD_LIM = 4'(MAX_BURST - 1);

  logic [SEL_W-1:0] last_grant;
  logic [3:0]       burst_cnt;
  logic             granted_once;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] cand;
  logic             win_vld;

  // granted_once keeps the reset value of last_grant from being treated as a
  // burst in progress, so the first grant after reset goes to channel 0.
  always_comb begin
    win     = '0;
    cand    = '0;
    win_vld = 1'b0;
    if (reset_L && !dest_full && (|request)) begin
      win_vld = 1'b1;
      if (prio_mode) begin
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          cand = SEL_W'(i);
          if (request[cand]) win = cand;
        end
      end else if (granted_once && request[last_grant] && (burst_cnt < HOLD_LIM)) begin
        win = last_grant;
      end else begin
        // descending scan so the nearest candidate after last_grant wins
        for (int k = NUM_CH; k >= 1; k--) begin
          cand = SEL_W'((int'(last_grant) + k) % NUM_CH);
          if (request[cand]) win = cand;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    if (win_vld) pop[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      last_grant   <= SEL_W'(NUM_CH - 1);
      burst_cnt    <= '0;
      granted_once <= 1'b0;
      port_sel     <= '0;
      valid_out    <= 1'b0;
    end else if (win_vld) begin
      port_sel     <= win;
      valid_out    <= 1'b1;
      last_grant   <= win;
      granted_once <= 1'b1;
      if (win == last_grant && !prio_mode)
        burst_cnt <= (burst_cnt != 4'hF) ? burst_cnt + 4'd1 : burst_cnt;
      else
        burst_cnt <= '0;
    end else begin
      valid_out <= 1'b0;
      // a stall keeps the burst count; only a true idle cycle clears it
      if (!dest_full) burst_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_round_robin_arb_n.sv
// Scoreboard bench for round_robin_arb_n: drivers push expected port_sel per
// pop, monitors compare whenever valid_out is presented.
module tb_round_robin_arb_n;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [3:0] request = '0;
  logic       dest_full = 1'b0;
  logic       prio_mode = 1'b0;
  logic [3:0] pop, pop1;
  logic [1:0] port_sel, port_sel1;
  logic       valid_out, valid1;

  int         tests = 0;
  int         fails = 0;
  logic [1:0] q[$];
  logic [1:0] q1[$];
  bit         mon1_en = 1'b0;

  always #5 clk = ~clk;

  round_robin_arb_n #(.NUM_CH(4), .MAX_BURST(2)) u_dut (
    .clk(clk), .reset_L(reset_L), .request(request), .dest_full(dest_full),
    .prio_mode(prio_mode), .pop(pop), .port_sel(port_sel), .valid_out(valid_out)
  );

  round_robin_arb_n #(.NUM_CH(4), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .reset_L(reset_L), .request(request), .dest_full(dest_full),
    .prio_mode(prio_mode), .pop(pop1), .port_sel(port_sel1), .valid_out(valid1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic step(input logic [3:0] req, input logic df, input logic pm,
                      input logic [3:0] exp, input logic [3:0] exp1, input bit c1);
    @(posedge clk); #1;
    request = req; dest_full = df; prio_mode = pm;
    @(negedge clk);
    chk("pop", pop, exp);
    if (exp != 0) q.push_back(idx_of(exp));
    if (c1) begin
      chk("pop_mb1", pop1, exp1);
      if (exp1 != 0) q1.push_back(idx_of(exp1));
    end
  endtask

  task automatic do_reset();
    request = '0; dest_full = 1'b0; prio_mode = 1'b0;
    @(posedge clk); #3;
    reset_L = 1'b0;
    #1;
    chk("rst_pop", pop, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_sel", port_sel, 0);
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
  endtask

  always @(posedge clk) begin
    #2;
    if (reset_L && valid_out) begin
      if (q.size() == 0) chk("sb_extra_valid", valid_out, 0);
      else chk("port_sel", port_sel, q.pop_front());
    end
    if (reset_L && mon1_en && valid1) begin
      if (q1.size() == 0) chk("sb_extra_valid_mb1", valid1, 0);
      else chk("port_sel_mb1", port_sel1, q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_a[9];
    logic [3:0] exp_b[4];
    logic [3:0] exp_b1[4];
    exp_a  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    exp_b  = '{4'b0010, 4'b0010, 4'b1000, 4'b1000};
    exp_b1 = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

    // all four requesting, burst of two each
    do_reset();
    for (int i = 0; i < 9; i++) step(4'hF, 1'b0, 1'b0, exp_a[i], 4'h0, 1'b0);
    step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

    // strict rotation with MAX_BURST=1 alongside the burst-2 instance
    do_reset();
    mon1_en = 1'b1;
    for (int i = 0; i < 4; i++) step(4'b1010, 1'b0, 1'b0, exp_b[i], exp_b1[i], 1'b1);
    step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    @(posedge clk); #3;
    mon1_en = 1'b0;

    // stall in the middle of a burst
    do_reset();
    step(4'b1010, 1'b0, 1'b0, 4'b0010, 4'h0, 1'b0);
    step(4'b1010, 1'b1, 1'b0, 4'b0000, 4'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(4'b1010, 1'b1, 1'b0, 4'b0000, 4'h0, 1'b0);
      chk("stall_valid", valid_out, 0);
      chk("stall_sel", port_sel, 1);
    end
    step(4'b1010, 1'b0, 1'b0, 4'b0010, 4'h0, 1'b0);
    step(4'b1010, 1'b0, 1'b0, 4'b1000, 4'h0, 1'b0);
    step(4'b1010, 1'b0, 1'b0, 4'b1000, 4'h0, 1'b0);
    step(4'b1010, 1'b0, 1'b0, 4'b0010, 4'h0, 1'b0);

    // fixed priority
    for (int i = 0; i < 3; i++) step(4'b1110, 1'b0, 1'b1, 4'b0010, 4'h0, 1'b0);
    step(4'b1100, 1'b0, 1'b1, 4'b0100, 4'h0, 1'b0);
    step(4'b0000, 1'b0, 1'b1, 4'b0000, 4'h0, 1'b0);

    // lone requester beyond the burst limit, then idle clears the burst count
    for (int i = 0; i < 5; i++) step(4'b0100, 1'b0, 1'b0, 4'b0100, 4'h0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0);
    step(4'b0110, 1'b0, 1'b0, 4'b0100, 4'h0, 1'b0);
    chk("idle_valid", valid_out, 0);
    step(4'b0110, 1'b0, 1'b0, 4'b0010, 4'h0, 1'b0);

    // asynchronous reset while a grant is active
    step(4'b1000, 1'b0, 1'b0, 4'b1000, 4'h0, 1'b0);
    @(posedge clk); #1;
    request = 4'hF;
    #1;
    chk("pre_reset_pop", pop, 4'b1000);
    #1;
    reset_L = 1'b0;
    #1;
    chk("async_pop", pop, 0);
    chk("async_valid", valid_out, 0);
    chk("async_sel", port_sel, 0);
    request = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
    step(4'hF, 1'b0, 1'b0, 4'b0001, 4'h0, 1'b0);
    step(4'h0, 1'b0, 1'b0, 4'b0000, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    #4;

    chk("sb_residue", q.size(), 0);
    chk("sb_residue_mb1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
